// File: rtl/replica_seq_ctrl.sv
// Command sequencer for the replica-exchange array: exchange table,
// opt-phase timing, distance micro-sequences and per-lane metropolis fan-out.
module replica_seq_ctrl #(
    parameter int REPLICA_NUM = 32,
    parameter int OPT_CNT_W   = 8,
    localparam int CW = $clog2(REPLICA_NUM + 1),
    localparam int IW = $clog2(REPLICA_NUM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_clear,
    input  logic                     cmd_set,
    input  logic [1:0]               cmd_data,
    input  logic                     run_command,
    input  logic [1:0]               run_exchange,
    input  logic                     run_distance,
    input  logic [1:0]               opt_mode,
    input  logic [OPT_CNT_W-1:0]     opt_cycles,
    input  logic [1:0]               c_metropolis,
    output logic [2*REPLICA_NUM-1:0] c_exchange,
    output logic [2*REPLICA_NUM-1:0] c_metropolis_out,
    output logic [4:0]               c_distance,
    output logic [1:0]               opt_command,
    output logic                     rbank,
    output logic                     busy,
    output logic                     dist_done,
    output logic [CW-1:0]            cmd_count,
    output logic                     cmd_overflow,
    output logic                     cmd_reject
);

    typedef enum logic [1:0] {S_IDLE, S_OPT, S_DIST} state_t;

    localparam logic [1:0] EX_NOP  = 2'd0;
    localparam logic [1:0] EX_PREV = 2'd1;
    localparam logic [1:0] EX_SELF = 2'd2;
    localparam logic [1:0] EX_FOLW = 2'd3;
    localparam logic [1:0] M_THR   = 2'd0;
    localparam logic [1:0] M_OR1   = 2'd1;
    localparam logic [1:0] M_TWO   = 2'd2;
    localparam logic [CW-1:0] FULL = CW'(REPLICA_NUM);

    function automatic logic [4:0] dist_step(input logic [1:0] m, input logic [2:0] k);
        dist_step = 5'h00;
        if (m == M_OR1) begin
            case (k)
                3'd0: dist_step = 5'h01;
                3'd1: dist_step = 5'h07;
                3'd2: dist_step = 5'h0A;
                3'd3: dist_step = 5'h03;
                3'd4: dist_step = 5'h0E;
                3'd5: dist_step = 5'h13;
                3'd6: dist_step = 5'h02;
                default: dist_step = 5'h00;
            endcase
        end else if (m == M_TWO) begin
            case (k)
                3'd0: dist_step = 5'h01;
                3'd1: dist_step = 5'h07;
                3'd2: dist_step = 5'h16;
                3'd3: dist_step = 5'h0F;
                3'd4: dist_step = 5'h02;
                default: dist_step = 5'h00;
            endcase
        end
    endfunction

    function automatic logic [2:0] dist_len(input logic [1:0] m);
        dist_len = (m == M_OR1) ? 3'd7 : (m == M_TWO) ? 3'd5 : 3'd0;
    endfunction

    state_t                   r_state;
    logic [OPT_CNT_W-1:0]     r_cnt;
    logic [2:0]               r_step;
    logic [1:0]               r_mode;
    logic                     r_rbank;
    logic                     r_busy;
    logic                     r_done;
    logic [CW-1:0]            r_count;
    logic                     r_ovf;
    logic                     r_rej;
    logic [2*REPLICA_NUM-1:0] r_exch;
    logic [4:0]               r_dist;
    logic [1:0]               r_table [REPLICA_NUM];

    logic                     w_idle;
    logic                     w_acc_run;
    logic                     w_acc_dist;
    logic                     w_acc_set;
    logic                     w_rej;
    logic                     w_room;
    logic [1:0]               w_mode;
    logic [OPT_CNT_W-1:0]     w_ncyc;
    logic [2*REPLICA_NUM-1:0] w_tbl;
    logic [2*REPLICA_NUM-1:0] w_met;

    assign w_idle     = (r_state == S_IDLE);
    assign w_acc_run  = w_idle & run_command;
    assign w_acc_dist = w_idle & ~run_command & run_distance;
    assign w_acc_set  = w_idle & ~run_command & ~run_distance & cmd_set;
    assign w_rej      = (run_command & ~w_acc_run)
                      | (run_distance & ~w_acc_dist)
                      | (cmd_set & ~w_acc_set);
    assign w_room     = (r_count < FULL);
    assign w_mode     = (opt_mode == 2'd3) ? M_THR : opt_mode;
    // Counter holds remaining OPT cycles after the first one
    assign w_ncyc     = (opt_cycles == '0) ? '0 : opt_cycles - 1'b1;

    always_comb begin
        w_tbl = '0;
        for (int i = 0; i < REPLICA_NUM; i++) begin
            if (CW'(i) < r_count) w_tbl[2*i +: 2] = r_table[i];
        end
    end

    always_comb begin
        w_met = '0;
        for (int i = 0; i < REPLICA_NUM; i++) begin
            unique case (c_metropolis)
                EX_PREV, EX_SELF: w_met[2*i +: 2] = c_metropolis;
                EX_FOLW: w_met[2*i +: 2] =
                    (r_exch[2*i +: 2] == EX_SELF) ? EX_NOP : r_exch[2*i +: 2];
                default: w_met[2*i +: 2] = EX_NOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_set && w_room) r_table[r_count[IW-1:0]] <= cmd_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_step  <= '0;
            r_mode  <= M_THR;
            r_rbank <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_rej   <= 1'b0;
            r_exch  <= '0;
            r_dist  <= 5'h00;
        end else begin
            r_exch <= '0;
            r_done <= 1'b0;
            if (w_rej) r_rej <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc_run) begin
                        r_rbank <= ~r_rbank;
                        if (run_exchange != EX_NOP) begin
                            r_exch <= {REPLICA_NUM{run_exchange}};
                        end else begin
                            r_exch  <= w_tbl;
                            r_count <= '0;
                        end
                        r_mode  <= w_mode;
                        r_cnt   <= w_ncyc;
                        r_busy  <= 1'b1;
                        r_state <= S_OPT;
                    end else if (w_acc_dist) begin
                        r_mode <= w_mode;
                        if (dist_len(w_mode) == 3'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_dist  <= dist_step(w_mode, 3'd0);
                            r_step  <= 3'd1;
                            r_busy  <= 1'b1;
                            r_state <= S_DIST;
                        end
                    end else if (w_acc_set) begin
                        if (w_room) r_count <= r_count + 1'b1;
                        else        r_ovf   <= 1'b1;
                    end
                end
                S_OPT: begin
                    if (r_cnt == '0) begin
                        r_mode  <= M_THR;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIST: begin
                    if (r_step == dist_len(r_mode)) begin
                        r_dist  <= 5'h00;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_dist <= dist_step(r_mode, r_step);
                        r_step <= r_step + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (cmd_clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_rej   <= 1'b0;
            end
        end
    end

    assign c_exchange       = r_exch;
    assign c_metropolis_out = w_met;
    assign c_distance       = r_dist;
    assign opt_command      = r_mode;
    assign rbank            = r_rbank;
    assign busy             = r_busy;
    assign dist_done        = r_done;
    assign cmd_count        = r_count;
    assign cmd_overflow     = r_ovf;
    assign cmd_reject       = r_rej;

endmodule

// File: doc/replica_seq_ctrl.md
# replica_seq_ctrl

Parametrised command sequencer for the replica-exchange array. It stores a per-replica exchange-command table and issues exchange and metropolis commands to each of `REPLICA_NUM` lanes. It also toggles the distance-RAM read bank and runs the opt and distance micro-sequences behind a busy/done handshake. It sits between the host command interface and the node chain. Beyond the fixed 32-lane controller it adds:
- a length-tracked table with overflow detection;
- a programmable opt-phase length;
- rejection flags;
- a done pulse.

## Interface
Parameters:
- `REPLICA_NUM`, default 32: number of lanes and table depth (≥2).
- `OPT_CNT_W`, default 8: width of `opt_cycles`.

Encodings:
- Exchange command (2b): NOP=0, PREV=1, SELF=2, FOLW=3.
- Opt mode (2b): THR=0, OR1=1, TWO=2; 3 is treated as THR.
- Distance command (5b) = {sel[2:0], op[1:0]}.
  - sel: KN=0, KM=1, KP=2, LN=3, LP=4, LM=5.
  - op: DNOP=0, ZERO=1, PLS=2, MNS=3.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_clear` in 1: clear the table count and the sticky flags.
- `cmd_set` in 1: append `cmd_data` to the table.
- `cmd_data` in 2: exchange command to append.
- `run_command` in 1: start an exchange/opt round.
- `run_exchange` in 2: immediate broadcast command; NOP selects the table.
- `run_distance` in 1: start a distance micro-sequence.
- `opt_mode` in 2: mode, latched on acceptance.
- `opt_cycles` in OPT_CNT_W: opt-phase length; 0 is treated as 1.
- `c_metropolis` in 2: metropolis command from the host.
- `c_exchange` out REPLICA_NUM*2: per-lane exchange command; lane i is bits [2i+1:2i].
- `c_metropolis_out` out REPLICA_NUM*2: per-lane metropolis command.
- `c_distance` out 5: distance micro-op.
- `opt_command` out 2: current opt mode.
- `rbank` out 1: distance-RAM bank select.
- `busy` out 1: sequencer not idle.
- `dist_done` out 1: one-cycle pulse at the end of a distance sequence.
- `cmd_count` out $clog2(REPLICA_NUM+1): table entries held.
- `cmd_overflow` out 1: sticky, a write was issued to a full table.
- `cmd_reject` out 1: sticky, a command was dropped.

## Operation
- FSM states: IDLE, OPT, DIST.
- Commands are accepted only in IDLE.
- Priority for same-cycle requests: run_command > run_distance > cmd_set.
- Any request not accepted (lower priority, or arriving while busy) sets `cmd_reject`.
- `cmd_set`, accepted:
  - If `cmd_count` < REPLICA_NUM: table[cmd_count] ← cmd_data and `cmd_count`++.
  - Otherwise the write is dropped and `cmd_overflow` is set.
- `run_command`, accepted:
  - `rbank` toggles.
  - `c_exchange` drives one cycle:
    - `run_exchange` ≠ NOP: every lane = run_exchange.
    - `run_exchange` = NOP: lane i = table[i] for i < cmd_count, NOP otherwise; `cmd_count` clears.
  - `opt_command` ← opt_mode, then the FSM enters OPT for max(opt_cycles,1) cycles.
  - On leaving OPT: `opt_command` ← THR and the FSM returns to IDLE.
- `run_distance`, accepted:
  - `opt_command` ← opt_mode and the FSM enters DIST.
  - One step per cycle:
    - OR1 (7 steps): 0x01, 0x07, 0x0A, 0x03, 0x0E, 0x13, 0x02.
    - TWO (5 steps): 0x01, 0x07, 0x16, 0x0F, 0x02.
    - THR: zero steps.
  - `c_distance` = 0x00 ({KN,DNOP}) outside steps.
  - `opt_command` holds the mode after DIST.
- `c_exchange` is NOP on every lane except the single issue cycle.
- `cmd_clear` works in any state and takes priority over `cmd_set` on the count and flags. It clears `cmd_count`, `cmd_overflow` and `cmd_reject`; table contents are don't-care.
- `c_metropolis_out` is combinational from `c_metropolis` and the registered `c_exchange`:
  - PREV or SELF: broadcast to all lanes.
  - FOLW: lane i = c_exchange[i], with SELF replaced by NOP.
  - NOP: all lanes NOP.

## Timing
- Reset values:
  - `c_exchange`, `c_distance`, `rbank`, `busy`, `dist_done`, `cmd_count`, `cmd_overflow`, `cmd_reject` all 0.
  - `opt_command` = THR.
  - FSM in IDLE.
- Reset mid-sequence aborts at the next edge with the reset values above.
- `run_command` sampled at edge T:
  - `rbank` and `c_exchange` update at T+1; `c_exchange` is NOP again at T+2.
  - `busy` is high for cycles T+1 … T+N, where N = max(opt_cycles,1).
  - `opt_command` = mode during T+1 … T+N and THR from T+N+1.
  - The next command is accepted at edge T+N+1.
- `run_distance` sampled at T, sequence of S steps:
  - step k is on `c_distance` in cycle T+1+k.
  - `busy` is high during T+1 … T+S.
  - `dist_done` is high in cycle T+S+1 while `busy` is low, and a new command is accepted at that edge.
  - For S=0: `dist_done` at T+1 and `busy` never rises.
- `cmd_count` increments visibly the cycle after an accepted `cmd_set`.
- Sticky flags set the cycle after the offending request.
- `cmd_set` and `run_command` in the same idle cycle: the run wins using the old table, and `cmd_reject` is set.

## Test plan
- **Table run:** with REPLICA_NUM=32, load PREV, SELF, FOLW, then `run_command` with `run_exchange`=NOP → lanes 0..2 = 1,2,3 and lanes 3..31 = 0 for one cycle; `cmd_count` 3→0; `rbank` 0→1.
- **Broadcast with FOLW metropolis:** `run_exchange`=SELF → all lanes 2 for one cycle; `c_metropolis`=FOLW in that cycle → all lanes NOP. Repeat with PREV → all lanes 1.
- **OR1 distance:** `run_distance` with mode OR1 → `c_distance` 01,07,0A,03,0E,13,02 over 7 cycles; `busy` high for 7 cycles; `dist_done` pulse on the 8th; `c_distance` then 0x00. TWO gives 01,07,16,0F,02.
- **Overflow:** 33 `cmd_set` writes → `cmd_count`=32 and `cmd_overflow`=1; `cmd_clear` → both 0.
- **Busy reject:** `opt_cycles`=5, `run_command`, then `run_distance` at T+3 → ignored and `cmd_reject`=1; `opt_command` returns to THR at T+6; `opt_cycles`=0 behaves as 1.
- **Reset mid-sequence:** reset at step 3 of OR1 → next cycle `c_distance`=0, `busy`=0, `opt_command`=THR, `rbank`=0, no `dist_done`.
